// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way dcache storage array: default geometry,
// entry field positions and the flush engine states.
package dcache_pkg;

  localparam int unsigned DEF_WAYS   = 4;
  localparam int unsigned DEF_SETS   = 16;
  localparam int unsigned DEF_TAG_W  = 23;
  localparam int unsigned DEF_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } flush_state_e;

  // Stored entry layout is {valid, dirty, tag[tag_w-1:0]}.
  function automatic int unsigned valid_bit(input int unsigned tag_w);
    return tag_w + 1;
  endfunction

  function automatic int unsigned dirty_bit(input int unsigned tag_w);
    return tag_w;
  endfunction

endpackage

// File: rtl/lru_age_set.sv
// True-LRU age vector of one set: touch update and victim choice.
// Purely combinational; the caller owns the age storage.
module lru_age_set #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS*AGE_W-1:0] age_i,
  input  logic [WAYS-1:0]       valid_mask_i,
  input  logic [AGE_W-1:0]      touch_way_i,
  output logic [WAYS*AGE_W-1:0] age_touch_c_o,
  output logic [AGE_W-1:0]      victim_c_o
);

  logic [AGE_W-1:0] touch_age;
  logic [AGE_W-1:0] cur_age;
  logic             found_inv;

  // Touched way becomes youngest; ways younger than it age by one.
  always_comb begin
    age_touch_c_o = age_i;
    touch_age     = age_i[touch_way_i*AGE_W +: AGE_W];
    cur_age       = '0;
    for (int w = 0; w < WAYS; w++) begin
      cur_age = age_i[w*AGE_W +: AGE_W];
      if (AGE_W'(w) == touch_way_i) begin
        age_touch_c_o[w*AGE_W +: AGE_W] = '0;
      end else if (cur_age < touch_age) begin
        age_touch_c_o[w*AGE_W +: AGE_W] = cur_age + AGE_W'(1);
      end
    end
  end

  // Lowest invalid way first, otherwise the oldest way.
  always_comb begin
    victim_c_o = '0;
    found_inv  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_mask_i[w]) begin
        victim_c_o = AGE_W'(w);
        found_inv  = 1'b1;
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_i[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) begin
          victim_c_o = AGE_W'(w);
        end
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache tag/data array with true-LRU replacement,
// registered lookup results and a dirty-line flush/write-back engine.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter  int unsigned WAYS   = DEF_WAYS,
  parameter  int unsigned SETS   = DEF_SETS,
  parameter  int unsigned TAG_W  = DEF_TAG_W,
  parameter  int unsigned LINE_W = DEF_LINE_W,
  localparam int unsigned IDX_W  = $clog2(SETS),
  localparam int unsigned ENT_W  = TAG_W + 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [ENT_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              rvalid_o,
  output logic              hit_o,
  output logic [ENT_W-1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  input  logic              flush_i,
  input  logic              flush_inv_i,
  output logic              busy_o,
  output logic              flush_done_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [IDX_W-1:0]  wb_set_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o
);

  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned VBIT  = valid_bit(TAG_W);
  localparam int unsigned DBIT  = dirty_bit(TAG_W);

  logic [ENT_W-1:0]       tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]      data_q [SETS][WAYS];
  logic [WAYS*WAY_W-1:0]  age_q  [SETS];

  flush_state_e           state_q, state_d;
  logic [IDX_W-1:0]       fset_q;
  logic [WAY_W-1:0]       fway_q;
  logic                   inv_q;

  logic                   rvalid_q, hit_q, busy_q, done_q, wb_valid_q;
  logic [ENT_W-1:0]       rtag_q;
  logic [LINE_W-1:0]      rdata_q;
  logic [IDX_W-1:0]       wb_set_q;
  logic [TAG_W-1:0]       wb_tag_q;
  logic [LINE_W-1:0]      wb_data_q;

  logic                   hit_c;
  logic [WAY_W-1:0]       hit_way_c, victim_c, sel_way_c;
  logic [WAYS-1:0]        valid_mask_c;
  logic [WAYS*WAY_W-1:0]  age_touch_c;
  logic [ENT_W-1:0]       f_ent_c;
  logic                   f_last_c;
  logic                   acc_en_c, flush_start_c, scan_adv_c, wb_start_c, wb_ack_c;

  // Tag compare on the addressed set; lowest matching way wins.
  always_comb begin
    hit_c        = 1'b0;
    hit_way_c    = '0;
    valid_mask_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_mask_c[w] = tag_q[addr_i][w][VBIT];
      if (!hit_c && tag_q[addr_i][w][VBIT] &&
          (tag_q[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  assign sel_way_c = hit_c ? hit_way_c : victim_c;

  lru_age_set #(
    .WAYS  (WAYS),
    .AGE_W (WAY_W)
  ) u_lru (
    .age_i         (age_q[addr_i]),
    .valid_mask_i  (valid_mask_c),
    .touch_way_i   (sel_way_c),
    .age_touch_c_o (age_touch_c),
    .victim_c_o    (victim_c)
  );

  assign f_ent_c  = tag_q[fset_q][fway_q];
  assign f_last_c = (fset_q == IDX_W'(SETS - 1)) && (fway_q == WAY_W'(WAYS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Flush sequencing; accesses are only honoured in IDLE.
  always_comb begin
    state_d       = state_q;
    acc_en_c      = 1'b0;
    flush_start_c = 1'b0;
    scan_adv_c    = 1'b0;
    wb_start_c    = 1'b0;
    wb_ack_c      = 1'b0;
    case (state_q)
      IDLE: begin
        acc_en_c = enable_i;
        if (flush_i) begin
          flush_start_c = 1'b1;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (f_ent_c[VBIT] && f_ent_c[DBIT]) begin
          wb_start_c = 1'b1;
          state_d    = WB;
        end else begin
          scan_adv_c = 1'b1;
          state_d    = f_last_c ? DONE : SCAN;
        end
      end
      WB: begin
        if (wb_ready_i) begin
          wb_ack_c = 1'b1;
          state_d  = f_last_c ? DONE : SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]                  <= '0;
          data_q[s][w]                 <= '0;
          age_q[s][w*WAY_W +: WAY_W]   <= WAY_W'(w);
        end
      end
      fset_q     <= '0;
      fway_q     <= '0;
      inv_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      hit_q      <= 1'b0;
      rtag_q     <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_set_q   <= '0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      rvalid_q <= acc_en_c && !write_i;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);

      if (acc_en_c && write_i) begin
        tag_q[addr_i][sel_way_c]  <= tag_i;
        data_q[addr_i][sel_way_c] <= data_i;
        age_q[addr_i]             <= age_touch_c;
      end

      // Miss returns the victim so the controller can decide on eviction.
      if (acc_en_c && !write_i) begin
        hit_q   <= hit_c;
        rtag_q  <= tag_q[addr_i][sel_way_c];
        rdata_q <= data_q[addr_i][sel_way_c];
        if (hit_c) age_q[addr_i] <= age_touch_c;
      end

      if (flush_start_c) begin
        inv_q  <= flush_inv_i;
        fset_q <= '0;
        fway_q <= '0;
      end

      if (scan_adv_c && inv_q) tag_q[fset_q][fway_q][VBIT] <= 1'b0;

      if (wb_start_c) begin
        wb_valid_q <= 1'b1;
        wb_set_q   <= fset_q;
        wb_tag_q   <= f_ent_c[TAG_W-1:0];
        wb_data_q  <= data_q[fset_q][fway_q];
      end

      if (wb_ack_c) begin
        wb_valid_q                   <= 1'b0;
        tag_q[fset_q][fway_q][DBIT]  <= 1'b0;
        if (inv_q) tag_q[fset_q][fway_q][VBIT] <= 1'b0;
      end

      if (scan_adv_c || wb_ack_c) begin
        fway_q <= fway_q + WAY_W'(1);
        if (fway_q == WAY_W'(WAYS - 1)) fset_q <= fset_q + IDX_W'(1);
      end
    end
  end

  assign rvalid_o     = rvalid_q;
  assign hit_o        = hit_q;
  assign tag_o        = rtag_q;
  assign data_o       = rdata_q;
  assign busy_o       = busy_q;
  assign flush_done_o = done_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_set_o     = wb_set_q;
  assign wb_tag_o     = wb_tag_q;
  assign wb_data_o    = wb_data_q;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed self-checking bench for dcache_sram_nway at default geometry.
module tb_dcache_sram_nway;

  localparam int unsigned TAG_W  = 23;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ENT_W  = TAG_W + 2;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              enable_i = 1'b0, write_i = 1'b0;
  logic [IDX_W-1:0]  addr_i = '0;
  logic [ENT_W-1:0]  tag_i = '0;
  logic [LINE_W-1:0] data_i = '0;
  logic              rvalid_o, hit_o;
  logic [ENT_W-1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              flush_i = 1'b0, flush_inv_i = 1'b0;
  logic              busy_o, flush_done_o, wb_valid_o;
  logic              wb_ready_i = 1'b0;
  logic [IDX_W-1:0]  wb_set_o;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [LINE_W-1:0] wb_data_o;

  int total = 0;
  int bad   = 0;

  dcache_sram_nway dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .tag_i(tag_i), .data_i(data_i),
    .rvalid_o(rvalid_o), .hit_o(hit_o), .tag_o(tag_o), .data_o(data_o),
    .flush_i(flush_i), .flush_inv_i(flush_inv_i), .busy_o(busy_o),
    .flush_done_o(flush_done_o), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_set_o(wb_set_o), .wb_tag_o(wb_tag_o), .wb_data_o(wb_data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [ENT_W-1:0] ent(input logic v, input logic d, input logic [TAG_W-1:0] t);
    return {v, d, t};
  endfunction

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] x);
    return {8{x}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0;
    flush_inv_i = 1'b0; wb_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic do_write(input logic [IDX_W-1:0] s, input logic [ENT_W-1:0] e, input logic [LINE_W-1:0] d);
    enable_i = 1'b1; write_i = 1'b1; addr_i = s; tag_i = e; data_i = d;
    tick();
    enable_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic do_lookup(input logic [IDX_W-1:0] s, input logic [TAG_W-1:0] t);
    enable_i = 1'b1; write_i = 1'b0; addr_i = s; tag_i = ent(1'b1, 1'b0, t);
    tick();
    enable_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({rvalid_o, hit_o, busy_o, flush_done_o, wb_valid_o} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {rvalid_o, hit_o, busy_o, flush_done_o, wb_valid_o}); end
    total++; if (tag_o !== '0 || data_o !== '0) begin
      bad++; $display("FAIL reset_rdata got tag=%h data=%h exp=0", tag_o, data_o); end
    total++; if (wb_set_o !== '0 || wb_tag_o !== '0 || wb_data_o !== '0) begin
      bad++; $display("FAIL reset_wb got set=%h tag=%h exp=0", wb_set_o, wb_tag_o); end
    do_lookup(4'd3, 23'h12);
    total++; if (rvalid_o !== 1'b1) begin bad++; $display("FAIL rst_lookup_rvalid got=%b exp=1", rvalid_o); end
    total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL rst_lookup_hit got=%b exp=0", hit_o); end
    total++; if (tag_o !== '0) begin bad++; $display("FAIL rst_lookup_tag got=%h exp=0", tag_o); end
    tick();
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL rvalid_pulse got=%b exp=0", rvalid_o); end
  endtask

  task automatic test_lru_replace();
    do_write(4'd5, ent(1, 0, 23'hA), pat(32'hA));
    do_write(4'd5, ent(1, 0, 23'hB), pat(32'hB));
    do_write(4'd5, ent(1, 0, 23'hC), pat(32'hC));
    do_write(4'd5, ent(1, 0, 23'hD), pat(32'hD));
    do_write(4'd5, ent(1, 0, 23'hE), pat(32'hE));
    total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL write_rvalid got=%b exp=0", rvalid_o); end
    do_lookup(4'd5, 23'hA);
    total++; if (hit_o !== 1'b0 || tag_o !== ent(1, 0, 23'hB)) begin
      bad++; $display("FAIL evict_a got hit=%b tag=%h exp hit=0 tag=%h", hit_o, tag_o, ent(1, 0, 23'hB)); end
    do_lookup(4'd5, 23'hE);
    total++; if (hit_o !== 1'b1 || data_o !== pat(32'hE)) begin
      bad++; $display("FAIL hit_e got hit=%b data=%h exp hit=1 data=%h", hit_o, data_o, pat(32'hE)); end
    do_lookup(4'd5, 23'hB);
    total++; if (hit_o !== 1'b1) begin bad++; $display("FAIL hit_b got=%b exp=1", hit_o); end
    do_write(4'd5, ent(1, 0, 23'hF), pat(32'hF));
    do_lookup(4'd5, 23'hC);
    total++; if (hit_o !== 1'b0 || tag_o !== ent(1, 0, 23'hD)) begin
      bad++; $display("FAIL evict_c got hit=%b tag=%h exp hit=0 tag=%h", hit_o, tag_o, ent(1, 0, 23'hD)); end
    do_lookup(4'd5, 23'hF);
    total++; if (hit_o !== 1'b1 || tag_o !== ent(1, 0, 23'hF) || data_o !== pat(32'hF)) begin
      bad++; $display("FAIL hit_f got hit=%b tag=%h exp hit=1 tag=%h", hit_o, tag_o, ent(1, 0, 23'hF)); end
  endtask

  task automatic test_back_to_back();
    logic [LINE_W-1:0] d55;
    d55 = {64{4'h5}};
    do_write(4'd2, ent(1, 1, 23'h7), d55);
    do_lookup(4'd2, 23'h7);
    total++; if (rvalid_o !== 1'b1 || hit_o !== 1'b1) begin
      bad++; $display("FAIL b2b_hit got rvalid=%b hit=%b exp 1 1", rvalid_o, hit_o); end
    total++; if (data_o !== d55) begin bad++; $display("FAIL b2b_data got=%h exp=%h", data_o, d55); end
    total++; if (tag_o !== ent(1, 1, 23'h7)) begin
      bad++; $display("FAIL b2b_tag got=%h exp=%h", tag_o, ent(1, 1, 23'h7)); end
  endtask

  task automatic test_flush_wb();
    int n;
    int dcount;
    do_reset();
    do_write(4'd0, ent(1, 0, 23'h100), pat(32'h100));
    do_write(4'd0, ent(1, 1, 23'h101), pat(32'h101));
    do_write(4'd15, ent(1, 0, 23'h200), pat(32'h200));
    do_write(4'd15, ent(1, 0, 23'h201), pat(32'h201));
    do_write(4'd15, ent(1, 0, 23'h202), pat(32'h202));
    do_write(4'd15, ent(1, 1, 23'h203), pat(32'h203));
    flush_i = 1'b1; flush_inv_i = 1'b0; wb_ready_i = 1'b0;
    tick();
    flush_i = 1'b0;
    n = 0;
    while (!wb_valid_o && n < 200) begin tick(); n++; end
    total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL wb1_timeout got=%b exp=1", wb_valid_o); end
    for (int i = 0; i < 4; i++) begin
      total++; if (wb_valid_o !== 1'b1 || busy_o !== 1'b1 || wb_set_o !== 4'd0 ||
                   wb_tag_o !== 23'h101 || wb_data_o !== pat(32'h101)) begin
        bad++; $display("FAIL wb1_hold%0d got v=%b set=%h tag=%h exp v=1 set=0 tag=101", i, wb_valid_o, wb_set_o, wb_tag_o); end
      if (i < 3) tick();
    end
    wb_ready_i = 1'b1;
    tick();
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL wb1_ack got=%b exp=0", wb_valid_o); end
    n = 0;
    while (!wb_valid_o && n < 200) begin tick(); n++; end
    total++; if (wb_valid_o !== 1'b1 || wb_set_o !== 4'd15 || wb_tag_o !== 23'h203 || wb_data_o !== pat(32'h203)) begin
      bad++; $display("FAIL wb2 got v=%b set=%h tag=%h exp v=1 set=f tag=203", wb_valid_o, wb_set_o, wb_tag_o); end
    tick();
    total++; if (flush_done_o !== 1'b1) begin bad++; $display("FAIL done_after_last got=%b exp=1", flush_done_o); end
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (flush_done_o) dcount++;
      tick();
    end
    wb_ready_i = 1'b0;
    total++; if (dcount != 1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL done_pulses got=%0d busy=%b exp=1 busy=0", dcount, busy_o); end
    do_lookup(4'd0, 23'h101);
    total++; if (hit_o !== 1'b1 || tag_o !== ent(1, 0, 23'h101)) begin
      bad++; $display("FAIL clean0 got hit=%b tag=%h exp hit=1 tag=%h", hit_o, tag_o, ent(1, 0, 23'h101)); end
    do_lookup(4'd15, 23'h203);
    total++; if (hit_o !== 1'b1 || tag_o !== ent(1, 0, 23'h203)) begin
      bad++; $display("FAIL clean15 got hit=%b tag=%h exp hit=1 tag=%h", hit_o, tag_o, ent(1, 0, 23'h203)); end
  endtask

  task automatic test_flush_inv();
    int n;
    int rv_seen;
    int dcount;
    flush_i = 1'b1; flush_inv_i = 1'b1;
    tick();
    flush_i = 1'b0; flush_inv_i = 1'b0;
    n = 0; rv_seen = 0; dcount = 0;
    while (busy_o && n < 200) begin
      if (rvalid_o) rv_seen++;
      if (flush_done_o) dcount++;
      enable_i = 1'b1; write_i = n[0]; addr_i = 4'd7;
      tag_i = ent(1, 0, 23'h77); data_i = pat(32'h77);
      n++;
      tick();
    end
    enable_i = 1'b0; write_i = 1'b0;
    total++; if (n != 65) begin bad++; $display("FAIL inv_busy_cycles got=%0d exp=65", n); end
    total++; if (rv_seen != 0) begin bad++; $display("FAIL inv_rvalid got=%0d exp=0", rv_seen); end
    total++; if (dcount != 1) begin bad++; $display("FAIL inv_done got=%0d exp=1", dcount); end
    do_lookup(4'd0, 23'h100);
    total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL inv_miss0 got=%b exp=0", hit_o); end
    do_lookup(4'd15, 23'h203);
    total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL inv_miss15 got=%b exp=0", hit_o); end
    do_lookup(4'd7, 23'h77);
    total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL ignored_write got=%b exp=0", hit_o); end
  endtask

  task automatic test_reset_in_wb();
    int n;
    int dseen;
    do_write(4'd4, ent(1, 1, 23'h44), pat(32'h44));
    flush_i = 1'b1; flush_inv_i = 1'b0; wb_ready_i = 1'b0;
    tick();
    flush_i = 1'b0;
    n = 0;
    while (!wb_valid_o && n < 200) begin tick(); n++; end
    total++; if (wb_valid_o !== 1'b1 || wb_set_o !== 4'd4) begin
      bad++; $display("FAIL rwb_reach got v=%b set=%h exp v=1 set=4", wb_valid_o, wb_set_o); end
    rst_i = 1'b1;
    tick();
    total++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0 || flush_done_o !== 1'b0) begin
      bad++; $display("FAIL rwb_abort got busy=%b v=%b done=%b exp 0 0 0", busy_o, wb_valid_o, flush_done_o); end
    rst_i = 1'b0;
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      if (flush_done_o || busy_o) dseen++;
      tick();
    end
    total++; if (dseen != 0) begin bad++; $display("FAIL rwb_quiet got=%0d exp=0", dseen); end
    do_lookup(4'd4, 23'h44);
    total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL rwb_miss got=%b exp=0", hit_o); end
  endtask

  initial begin
    test_reset();
    test_lru_replace();
    test_back_to_back();
    test_flush_wb();
    test_flush_inv();
    test_reset_in_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_sram_nway.md
Name: dcache_sram_nway

Overview:
Parametrised N-way set-associative data-cache storage array with true-LRU replacement. It succeeds the fixed 2-way/16-set dcache SRAM and adds configurable ways, sets and line width, registered read outputs, and a flush engine that writes back dirty lines over a valid/ready channel. It sits between the dcache controller (lookup/write port) and the data-memory interface (flush write-back port).

Parameters:
WAYS, 4, associativity; power of 2, >= 2
SETS, 16, number of sets; power of 2
TAG_W, 23, address tag bits; stored entry is {valid, dirty, tag} = TAG_W+2 bits
LINE_W, 256, cache line width in bits
IDX_W, $clog2(SETS), set index width (derived, not overridden)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
enable_i  in  1  access request, one per cycle
write_i  in  1  1 = write/fill, 0 = lookup
addr_i  in  IDX_W  set index
tag_i  in  TAG_W+2  {valid, dirty, tag}
data_i  in  LINE_W  write/fill line
rvalid_o  out  1  read result valid (one cycle after a lookup)
hit_o  out  1  lookup hit
tag_o  out  TAG_W+2  hit-way entry on a hit, victim entry on a miss
data_o  out  LINE_W  hit-way line on a hit, victim line on a miss
flush_i  in  1  start-flush pulse
flush_inv_i  in  1  also invalidate lines during the flush; sampled with flush_i
busy_o  out  1  flush in progress
flush_done_o  out  1  one-cycle pulse when the flush completes
wb_valid_o  out  1  write-back line available
wb_ready_i  in  1  memory accepts the write-back
wb_set_o  out  IDX_W  write-back set index
wb_tag_o  out  TAG_W  write-back tag
wb_data_o  out  LINE_W  write-back line

Behaviour:
- Reset (synchronous):
  - all entries cleared: valid = 0, dirty = 0, tag = 0, data = 0
  - LRU age of way w = w in every set
  - FSM set to IDLE
  - all outputs 0
  - a reset during a flush aborts it, with no write-back or done pulse.
- Hit:
  - way w hits when stored valid = 1 and stored tag == tag_i[TAG_W-1:0].
  - At most one way can hit. If several do (a controller error), the lowest-index way is used.
- Victim selection:
  - the lowest-index invalid way, if any;
  - otherwise the way whose age == WAYS-1.
- LRU touch of way w:
  - every way with age < age(w) increments;
  - way w's age becomes 0;
  - the ages in a set always form a permutation of 0..WAYS-1.
- Lookup (enable_i = 1, write_i = 0, in IDLE):
  - rvalid_o = 1 in the next cycle, with hit_o/tag_o/data_o registered.
  - On a hit, the hit way is touched.
  - On a miss, LRU is unchanged and the victim entry is returned so the controller can decide on a write-back.
  - Outputs hold their value until the next lookup; rvalid_o is 0 in every other cycle.
- Write (enable_i = 1, write_i = 1, in IDLE):
  - tag_i and data_i are written to the hit way, or to the victim way on a miss; that way is touched.
  - The write is visible to a lookup issued in the next cycle.
  - rvalid_o stays 0.
- Flush FSM:
  - IDLE: when flush_i = 1, latch flush_inv_i, reset the (set, way) counter to (0, 0), and go to SCAN next cycle. An access in the same cycle is still performed.
  - SCAN: examine one entry per cycle.
    - Valid and dirty: go to WB.
    - Otherwise: if flush_inv_i was latched, clear valid; advance the counter.
    - After entry (SETS-1, WAYS-1): go to DONE.
  - WB: drive wb_valid_o = 1 with the entry's set, tag and data, held stable until wb_ready_i = 1.
    - On handshake: clear dirty (and valid if flush_inv_i was latched), advance the counter, and go to SCAN or DONE.
  - DONE: flush_done_o = 1 for one cycle, then IDLE.
  - busy_o = 1 in SCAN, WB and DONE.
  - enable_i and flush_i are ignored while busy_o = 1: no state change, rvalid_o = 0.
  - LRU ages are not modified by a flush.
- Flush latency: a flush with no dirty lines takes SETS*WAYS SCAN cycles plus one DONE cycle.

Decomposition:
- Shared package (dcache_pkg):
  - TAG_W, LINE_W, SETS, WAYS defaults;
  - entry field positions (VALID_BIT = TAG_W+1, DIRTY_BIT = TAG_W);
  - flush state enum {IDLE, SCAN, WB, DONE}.
- One natural sub-module, lru_age_set: the per-set age vector with a touch(way) update and a victim(valid_mask) output.
- Array storage and the flush FSM stay in the top module.

Test Plan:
- After reset, lookup set 3 with tag 0x12 -> next cycle rvalid_o = 1, hit_o = 0, tag_o = 0 (victim is way 0, invalid).
- Write tags 0xA, 0xB, 0xC, 0xD to set 5, then write 0xE -> 0xE replaces 0xA (way 0).
  - Then lookup 0xB, write 0xF -> 0xF replaces 0xC (way 2).
- Write {1,1,0x7} with data 0x55..55 to set 2, then lookup next cycle -> hit_o = 1, data_o = 0x55..55, tag_o = {1,1,0x7}.
- Make lines at set 0 way 1 and set 15 way 3 dirty; flush_i with flush_inv_i = 0 and wb_ready_i held low for 3 cycles.
  - wb_valid_o stays high with stable set 0, tag and data for those 3 cycles.
  - Two write-backs occur in order; flush_done_o pulses once.
  - A later lookup hits those lines with dirty = 0.
- Flush with flush_inv_i = 1 and no dirty lines -> busy_o high for exactly 65 cycles (64 SCAN + DONE); afterwards every lookup misses.
  - enable_i asserted during the flush -> rvalid_o stays 0 and the arrays are unchanged.
- Assert rst_i while in WB -> next cycle busy_o = 0, wb_valid_o = 0, no flush_done_o, and all lookups miss.
